// File: rtl/fft_twiddle_sequencer.sv
// rtl/fft_twiddle_sequencer.sv - radix-2 DIF butterfly schedule and twiddle address sequencer
module fft_twiddle_sequencer #(
  parameter int LOG2N = 6,
  parameter int BW    = LOG2N - 1,
  parameter int SW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inverse,
  input  logic          valid,
  output logic          busy,
  output logic          tw_valid,
  output logic [SW-1:0] stage,
  output logic [BW-1:0] bfly,
  output logic [BW-1:0] tw_addr,
  output logic          tw_bypass,
  output logic          tw_conj,
  output logic          last_bfly,
  output logic          done
);

  localparam logic [BW-1:0] BFLY_LAST  = {BW{1'b1}};
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [SW-1:0] stg_cnt;
  logic [BW-1:0] bfly_cnt;
  logic          inv_lat;
  logic [BW-1:0] k;

  // Twiddle index: keep the low (BW-s) bits of j and shift by s; the shift
  // truncated to BW bits does exactly that, and the last stage lands on 0.
  always_comb begin
    k = bfly_cnt << stg_cnt;
  end

  // Schedule FSM; every output is registered and describes the butterfly
  // accepted on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stg_cnt   <= '0;
      bfly_cnt  <= '0;
      inv_lat   <= 1'b0;
      busy      <= 1'b0;
      tw_valid  <= 1'b0;
      stage     <= '0;
      bfly      <= '0;
      tw_addr   <= '0;
      tw_bypass <= 1'b0;
      tw_conj   <= 1'b0;
      last_bfly <= 1'b0;
      done      <= 1'b0;
    end else begin
      tw_valid  <= 1'b0;
      tw_conj   <= 1'b0;
      last_bfly <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            inv_lat  <= inverse;
            stg_cnt  <= '0;
            bfly_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (valid) begin
            tw_valid  <= 1'b1;
            stage     <= stg_cnt;
            bfly      <= bfly_cnt;
            tw_addr   <= k;
            tw_bypass <= (k == '0);
            tw_conj   <= inv_lat;
            last_bfly <= (bfly_cnt == BFLY_LAST);
            if (bfly_cnt == BFLY_LAST) begin
              bfly_cnt <= '0;
              if (stg_cnt == STAGE_LAST) begin
                stg_cnt <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= IDLE;
              end else begin
                stg_cnt <= stg_cnt + 1'b1;
              end
            end else begin
              bfly_cnt <= bfly_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb/tb_fft_twiddle_sequencer.sv - directed self-checking bench for fft_twiddle_sequencer
module tb_fft_twiddle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
  logic       valid = 1'b0;
  logic       busy;
  logic       tw_valid;
  logic [2:0] stage;
  logic [4:0] bfly;
  logic [4:0] tw_addr;
  logic       tw_bypass;
  logic       tw_conj;
  logic       last_bfly;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  fft_twiddle_sequencer #(.LOG2N(6), .BW(5), .SW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .valid(valid),
    .busy(busy), .tw_valid(tw_valid), .stage(stage), .bfly(bfly),
    .tw_addr(tw_addr), .tw_bypass(tw_bypass), .tw_conj(tw_conj),
    .last_bfly(last_bfly), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tw_valid"}, tw_valid, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_bfly"}, bfly, 0);
    check({tag, "_tw_addr"}, tw_addr, 0);
    check({tag, "_tw_bypass"}, tw_bypass, 0);
    check({tag, "_tw_conj"}, tw_conj, 0);
    check({tag, "_last_bfly"}, last_bfly, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Runs one frame after its start was accepted; the model walks (s, j)
  // independently and computes k as (j mod span) << s.
  task automatic run_frame(input bit gaps, input bit inject_start, input bit inject_rst,
                           input bit exp_conj);
    int s = 0;
    int j = 0;
    int pulses = 0;
    int lasts = 0;
    int cyc = 0;
    int span;
    int kexp;
    bit v;
    bit done_seen = 0;
    bit is_final;
    while (!done_seen && cyc < 2000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      valid = v;
      start = 1'b0;
      rst = 1'b0;
      if (v && inject_start && s == 2 && j == 7) begin
        start = 1'b1;
        inverse = ~inverse;
      end
      if (v && inject_rst && s == 3 && j == 10) rst = 1'b1;
      step();
      cyc++;
      if (rst) begin
        check_all_zero("midframe_rst");
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      if (!v) begin
        check("gap_tw_valid", tw_valid, 0);
        check("gap_busy", busy, 1);
      end else begin
        span = 64 >> (s + 1);
        kexp = ((j % span) << s) & 31;
        is_final = (s == 5 && j == 31);
        check("tw_valid", tw_valid, 1);
        check("stage", stage, s);
        check("bfly", bfly, j);
        check("tw_addr", tw_addr, kexp);
        check("tw_bypass", tw_bypass, (kexp == 0));
        check("tw_conj", tw_conj, exp_conj);
        check("last_bfly", last_bfly, (j == 31));
        check("done", done, is_final);
        check("busy", busy, !is_final);
        if (s == 0 && j == 13) check("k_s0_j13", tw_addr, 13);
        if (s == 1 && j == 21) check("k_s1_j21", tw_addr, 10);
        if (s == 2 && j == 13) check("k_s2_j13", tw_addr, 20);
        if (s == 4 && j == 13) check("k_s4_j13", tw_addr, 16);
        if (s == 5 && j == 19) check("k_s5_j19", tw_addr, 0);
        pulses++;
        if (last_bfly) lasts++;
        if (done) done_seen = 1;
        if (j == 31) begin
          j = 0;
          s++;
        end else begin
          j++;
        end
      end
    end
    valid = 1'b0;
    start = 1'b0;
    check("frame_done_seen", done_seen, 1);
    check("frame_pulses", pulses, 192);
    check("frame_last_bfly_count", lasts, 6);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Frame A: forward, valid held high
    start = 1'b1;
    inverse = 1'b0;
    valid = 1'b1;
    step();
    check("a_busy_after_start", busy, 1);
    check("a_no_tw_yet", tw_valid, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Frame B: started in A's done cycle, inverse, random gaps, mid-frame start/inverse
    start = 1'b1;
    inverse = 1'b1;
    valid = 1'b1;
    step();
    check("b_busy_after_start", busy, 1);
    check("b_no_tw_yet", tw_valid, 0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b1);

    // Frame C: reset at stage 3, bfly 10
    step();
    step();
    check("idle_busy", busy, 0);
    start = 1'b1;
    inverse = 1'b0;
    valid = 1'b1;
    step();
    check("c_busy_after_start", busy, 1);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_busy", busy, 0);
      check("post_rst_tw_valid", tw_valid, 0);
      check("post_rst_done", done, 0);
    end

    // rst and start together: no frame starts
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_start_busy", busy, 0);
      check("rst_start_tw_valid", tw_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
- Sequences the butterfly schedule of the in-place radix-2 DIF FFT core: stage index, butterfly index and twiddle-ROM address, one butterfly per advance cycle.
- Sits beside the bank/address control block. It drives the twiddle ROM address and the twiddle-multiplier bypass, and reports frame completion to the host-side frame logic.
- Default frame size is 64 points: 6 stages × 32 butterflies.

Parameters:
- LOG2N, 6, log2 of FFT size N; number of stages equals LOG2N.
- BW, 5, butterfly/twiddle index width; fixed at LOG2N-1.
- SW, 3, stage index width; must satisfy 2^SW ≥ LOG2N.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  frame start request; sampled only in IDLE.
- inverse  in  1  IFFT select; latched on accepted start.
- valid  in  1  advance enable; one butterfly is consumed per cycle with valid=1 in RUN.
- busy  out  1  high while in RUN.
- tw_valid  out  1  registered strobe: tw_addr/stage/bfly/tw_bypass/tw_conj describe one butterfly.
- stage  out  SW  stage of the emitted butterfly, 0..LOG2N-1.
- bfly  out  BW  butterfly index within the stage, 0..N/2-1.
- tw_addr  out  BW  twiddle ROM index k (W_N^k).
- tw_bypass  out  1  high when k==0 (multiply by 1, skip multiplier).
- tw_conj  out  1  latched inverse, qualified by tw_valid.
- last_bfly  out  1  high with the tw_valid of bfly==N/2-1 in any stage.
- done  out  1  one-cycle pulse coinciding with tw_valid of the final butterfly of the frame.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. No other reset source.
- Reset values: state=IDLE, all counters 0, busy/tw_valid/last_bfly/done/tw_bypass/tw_conj=0, stage/bfly/tw_addr=0.
- FSM, two states:
  - IDLE: start=1 latches inverse, clears counters, moves to RUN next edge; valid ignored.
  - RUN: start ignored. With valid=1 the current (stage, bfly) is accepted and bfly increments.
  - When bfly == N/2-1 is accepted: bfly wraps to 0 and stage increments.
  - When stage == LOG2N-1 and bfly == N/2-1 is accepted: go to IDLE.
- Twiddle rule for stage s, butterfly j:
  - span = N >> (s+1)
  - k = (j mod span) << s, truncated to BW bits
  - Equivalently: mask the low (BW-s) bits of j, then shift left by s.
  - Stage LOG2N-1 always gives k=0.
- Latency: outputs are registered, exactly 1 cycle after the accepting valid cycle.
  - tw_valid = registered (RUN & valid).
  - Output fields hold their last values when tw_valid=0.
- valid=0 in RUN: counters freeze; tw_valid=0 the next cycle. No butterfly is skipped or repeated.
- busy: rises the cycle after the accepted start; falls the same edge that asserts done/final tw_valid.
- Back-to-back frames: start is accepted in the cycle done is high (state already IDLE). The first tw_valid of the new frame is then no earlier than 2 cycles after that.
- rst mid-frame: state, counters and every output return to reset values at that edge; no done pulse is emitted.
- rst and start in the same cycle: rst wins; start is dropped.
- Frame length: exactly LOG2N·N/2 tw_valid pulses (192 for the default).

Test Plan:
- rst; start=1 for 1 cycle with inverse=0; valid held 1 → busy=1 next cycle. First tw_valid 2 cycles after start shows stage=0, bfly=0, tw_addr=0, tw_bypass=1. Exactly 192 tw_valid pulses; done on the last with stage=5, bfly=31, tw_addr=0; busy=0 that cycle.
- Twiddle spot checks in the same frame:
  - (s=0, j=13) → k=13
  - (s=1, j=21) → k=10
  - (s=2, j=13) → k=20
  - (s=4, j=13) → k=16
  - (s=5, j=any) → k=0, tw_bypass=1
  - last_bfly high only at j=31, 6 times per frame.
- Random valid gaps, 50% duty → tw_valid count still 192; (stage, bfly) sequence strictly monotonic with no repeats; tw_valid=0 exactly 1 cycle after each valid=0 cycle.
- start pulsed during RUN (stage 2, bfly 7) → ignored; frame continues and completes normally. inverse toggled mid-frame → tw_conj unchanged.
- rst asserted at stage 3, bfly 10, then released with no start → all outputs 0 next cycle; no done pulse; state stays IDLE.
- start in the done cycle with inverse=1 → second frame starts; first tw_valid 2 cycles later with stage=0, bfly=0, tw_conj=1. rst and start together → no frame starts.
